sad_search_ctrl: RTL and testbench

Sequencer that drives the combinational SAD datapath (two 128-bit operands of 16 pixels each, 12-bit SAD result) to run a full-search block match.
- For each of num_cand candidate blocks, it streams ROWS row-pairs (current row, candidate row) from two external synchronous-read memories through the SAD unit and accumulates one SAD per candidate.
- It keeps the minimum SAD and its candidate index.
- It sits between the frame-buffer row memories and one shared SAD instance.

---
 rtl/sad_search_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sad_search_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_search_ctrl.sv
// Full-search block-match sequencer around one shared combinational SAD unit.
// Streams row pairs per candidate, accumulates SAD, keeps the minimum.
module sad_search_ctrl #(
   parameter int ROWS   = 16,
   parameter int CAND_W = 6,
   parameter int ACC_W  = 16,
   localparam int RW    = $clog2(ROWS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CAND_W-1:0] num_cand,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [RW-1:0]     row_idx,
   output logic [CAND_W-1:0] cand_idx,
   input  logic [127:0]      cur_row,
   input  logic [127:0]      cand_row,
   output logic [127:0]      sad_pA,
   output logic [127:0]      sad_pB,
   input  logic [11:0]       sad_result,
   output logic [ACC_W-1:0]  best_sad,
   output logic [CAND_W-1:0] best_idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_CMP,
      S_DONE
   } state_t;

   state_t              state_q;
   logic [CAND_W-1:0]   ncand_q;
   logic [CAND_W-1:0]   cand_q;
   logic [RW-1:0]       row_q;
   logic                drain_q;
   logic                busy_q;
   logic                done_q;
   logic                rd_q;
   logic [ACC_W-1:0]    acc_q;
   logic [ACC_W-1:0]    best_sad_q;
   logic [CAND_W-1:0]   best_idx_q;
   logic                v1_q;
   logic                v2_q;
   logic [127:0]        pa_q;
   logic [127:0]        pb_q;
   logic [ACC_W-1:0]    sad_ext;

   assign sad_ext = {{(ACC_W-12){1'b0}}, sad_result};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ncand_q    <= '0;
         cand_q     <= '0;
         row_q      <= '0;
         drain_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_q       <= 1'b0;
         acc_q      <= '0;
         best_sad_q <= '1;
         best_idx_q <= '0;
      end else begin
         if (v2_q) begin
            acc_q <= acc_q + sad_ext;
         end
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  ncand_q    <= num_cand;
                  best_sad_q <= '1;
                  best_idx_q <= '0;
                  cand_q     <= '0;
                  row_q      <= '0;
                  acc_q      <= '0;
                  if (num_cand == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_ISSUE;
                     busy_q  <= 1'b1;
                     rd_q    <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (row_q == RW'(ROWS - 1)) begin
                  rd_q    <= 1'b0;
                  row_q   <= '0;
                  drain_q <= 1'b0;
                  state_q <= S_DRAIN;
               end else begin
                  row_q <= row_q + RW'(1);
               end
            end
            S_DRAIN: begin
               // two cycles: operand register, then accumulator
               drain_q <= ~drain_q;
               if (drain_q) begin
                  state_q <= S_CMP;
               end
            end
            S_CMP: begin
               if (acc_q < best_sad_q) begin
                  best_sad_q <= acc_q;
                  best_idx_q <= cand_q;
               end
               acc_q <= '0;
               if (cand_q == ncand_q - CAND_W'(1)) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  cand_q  <= cand_q + CAND_W'(1);
                  rd_q    <= 1'b1;
                  state_q <= S_ISSUE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         pa_q <= '0;
         pb_q <= '0;
      end else begin
         v1_q <= rd_q;
         v2_q <= v1_q;
         if (v1_q) begin
            pa_q <= cur_row;
            pb_q <= cand_row;
         end
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_en    = rd_q;
   assign row_idx  = row_q;
   assign cand_idx = cand_q;
   assign sad_pA   = pa_q;
   assign sad_pB   = pb_q;
   assign best_sad = best_sad_q;
   assign best_idx = best_idx_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl: row memories and SAD unit modelled here,
// expected results computed from block sums and the cycle schedule.
module tb_sad_search_ctrl;
   localparam int ROWS   = 16;
   localparam int CAND_W = 6;
   localparam int ACC_W  = 16;
   localparam int RW     = $clog2(ROWS);
   localparam int PER    = ROWS + 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start = 1'b0;
   logic [CAND_W-1:0] num_cand = '0;
   logic              busy, done, rd_en;
   logic [RW-1:0]     row_idx;
   logic [CAND_W-1:0] cand_idx;
   logic [127:0]      cur_q = '0;
   logic [127:0]      cand_q = '0;
   logic [127:0]      sad_pA, sad_pB;
   logic [11:0]       sad_res;
   logic [ACC_W-1:0]  best_sad;
   logic [CAND_W-1:0] best_idx;

   sad_search_ctrl #(
      .ROWS(ROWS), .CAND_W(CAND_W), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_cand(num_cand),
      .busy(busy), .done(done), .rd_en(rd_en), .row_idx(row_idx),
      .cand_idx(cand_idx), .cur_row(cur_q), .cand_row(cand_q),
      .sad_pA(sad_pA), .sad_pB(sad_pB), .sad_result(sad_res),
      .best_sad(best_sad), .best_idx(best_idx)
   );

   always #5 clk = ~clk;

   logic [127:0] cur_mem [ROWS];
   logic [127:0] cand_mem [4][ROWS];

   function automatic logic [11:0] sad16(input logic [127:0] a,
                                         input logic [127:0] b);
      int s;
      s = 0;
      for (int p = 0; p < 16; p++) begin
         int x, y;
         x = int'(a[8*p +: 8]);
         y = int'(b[8*p +: 8]);
         s += (x > y) ? x - y : y - x;
      end
      return s[11:0];
   endfunction

   always @(posedge clk) begin
      if (rd_en) begin
         cur_q  <= cur_mem[row_idx];
         cand_q <= cand_mem[cand_idx[1:0]][row_idx];
      end
   end

   always_comb sad_res = sad16(sad_pA, sad_pB);

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit active = 1'b0;
   bit fin = 1'b0;
   int m_n, m_best, m_idx, m_done;

   task automatic chk(input string name, input longint act,
                      input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic model(input int n);
      m_n = n;
      m_best = (1 << ACC_W) - 1;
      m_idx = 0;
      for (int k = 0; k < n; k++) begin
         int s;
         s = 0;
         for (int r = 0; r < ROWS; r++) s += int'(sad16(cur_mem[r], cand_mem[k][r]));
         if (s < m_best) begin
            m_best = s;
            m_idx = k;
         end
      end
      m_done = (n == 0) ? 1 : PER * n + 1;
   endtask

   initial forever begin
      @(negedge clk);
      if (active) begin
         bit eb, erd;
         int k, ph;
         cyc++;
         eb = (m_n > 0) && (cyc >= 1) && (cyc <= m_done);
         erd = 1'b0;
         k = 0;
         ph = 0;
         if (m_n > 0 && cyc >= 1 && cyc < m_done) begin
            k = (cyc - 1) / PER;
            ph = (cyc - 1) % PER;
            erd = (ph < ROWS);
         end
         chk("busy", busy, eb);
         chk("done", done, cyc == m_done);
         chk("rd_en", rd_en, erd);
         if (erd) begin
            chk("row_idx", row_idx, ph);
            chk("cand_idx", cand_idx, k);
         end
         if (cyc >= m_done) begin
            chk("best_sad", best_sad, m_best);
            chk("best_idx", best_idx, m_idx);
         end else if (cyc >= 1 && cyc <= PER) begin
            chk("best_sad_init", best_sad, (1 << ACC_W) - 1);
         end
         if (cyc == m_done + 2) begin
            active = 1'b0;
            fin = 1'b1;
         end
      end
   end

   task automatic fill_cur();
      for (int r = 0; r < ROWS; r++)
         for (int p = 0; p < 16; p++)
            cur_mem[r][8*p +: 8] = 8'(20 + (r * 7 + p * 3) % 200);
   endtask

   task automatic fill_cand(input int k, input int off);
      for (int r = 0; r < ROWS; r++)
         for (int p = 0; p < 16; p++)
            cand_mem[k][r][8*p +: 8] = 8'(int'(cur_mem[r][8*p +: 8]) + off);
   endtask

   task automatic run(input int n, input int lb, input int li,
                      input int ld, input int restart_at,
                      input int row_lit, input int rst_at);
      model(n);
      chk("model_best", m_best, lb);
      chk("model_idx", m_idx, li);
      chk("model_done", m_done, ld);
      @(posedge clk);
      #1;
      num_cand = CAND_W'(n);
      start = 1'b1;
      cyc = -1;
      fin = 1'b0;
      active = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (restart_at > 0) begin
         wait (cyc == restart_at);
         num_cand = CAND_W'(n + 1);
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      if (row_lit >= 0) begin
         wait (cyc == 3);
         chk("row_sad", sad_res, row_lit);
      end
      if (rst_at > 0) begin
         wait (cyc == rst_at);
         active = 1'b0;
         rst_n = 1'b0;
         #1;
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_rd_en", rd_en, 0);
         chk("rst_row_idx", row_idx, 0);
         chk("rst_cand_idx", cand_idx, 0);
         chk("rst_pA", sad_pA == '0, 1);
         chk("rst_pB", sad_pB == '0, 1);
         chk("rst_best_sad", best_sad, (1 << ACC_W) - 1);
         chk("rst_best_idx", best_idx, 0);
         repeat (3) begin
            @(negedge clk);
            chk("rst_hold_done", done, 0);
            chk("rst_hold_busy", busy, 0);
         end
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         return;
      end
      for (int i = 0; i < 3000 && !fin; i++) @(posedge clk);
      if (!fin) begin
         checks++;
         failures++;
         active = 1'b0;
         $display("FAIL timeout n=%0d cyc=%0d", n, cyc);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      #20;
      chk("init_busy", busy, 0);
      chk("init_done", done, 0);
      chk("init_rd_en", rd_en, 0);
      chk("init_best_sad", best_sad, 16'hFFFF);
      chk("init_best_idx", best_idx, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      fill_cur();
      fill_cand(0, 1);
      fill_cand(1, 1);
      fill_cand(2, 0);
      run(3, 0, 2, 58, 0, -1, 0);

      fill_cand(0, 1);
      fill_cand(1, -1);
      fill_cand(2, 1);
      for (int p = 0; p < 12; p++)
         cand_mem[2][0][8*p +: 8] = cur_mem[0][8*p +: 8] + 8'd5;
      for (int p = 12; p < 16; p++)
         cand_mem[2][0][8*p +: 8] = cur_mem[0][8*p +: 8];
      run(3, 256, 0, 58, 0, -1, 0);

      for (int r = 0; r < ROWS; r++) begin
         cur_mem[r] = '0;
         cand_mem[0][r] = '1;
      end
      run(1, 65280, 0, 20, 0, 4080, 0);

      run(0, 65535, 0, 1, 0, -1, 0);

      fill_cur();
      fill_cand(0, 2);
      fill_cand(1, 1);
      run(2, 256, 1, 39, 10, -1, 0);

      fill_cand(0, 1);
      fill_cand(1, 1);
      fill_cand(2, 0);
      run(3, 0, 2, 58, 0, -1, 25);
      run(3, 0, 2, 58, 0, -1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
